// File: rtl/chain_pkg.sv
// Shared constants and helpers for the chain-code decoder/plotter pair.
//   CC_IMG_DIM / CC_ADDR_W : image size and coordinate width
//   CC_PERIM_W             : default perimeter counter width
//   state_t                : plotter FSM encoding
//   code_step()            : Freeman code -> signed (dx,dy); row index grows downward
package chain_pkg;
  localparam int CC_IMG_DIM = 64;
  localparam int CC_ADDR_W  = 6;
  localparam int CC_PERIM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PLOT_RD, S_PLOT_WAIT, S_PLOT_WR, S_WAIT_CODE, S_DONE
  } state_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } step_t;

  function automatic step_t code_step(input logic [2:0] c);
    case (c)
      3'd0:    code_step = step_t'{dx: 2'b01, dy: 2'b00};
      3'd1:    code_step = step_t'{dx: 2'b01, dy: 2'b11};
      3'd2:    code_step = step_t'{dx: 2'b00, dy: 2'b11};
      3'd3:    code_step = step_t'{dx: 2'b11, dy: 2'b11};
      3'd4:    code_step = step_t'{dx: 2'b11, dy: 2'b00};
      3'd5:    code_step = step_t'{dx: 2'b11, dy: 2'b01};
      3'd6:    code_step = step_t'{dx: 2'b00, dy: 2'b01};
      default: code_step = step_t'{dx: 2'b01, dy: 2'b01};
    endcase
  endfunction
endpackage

// File: rtl/chain_step.sv
// Combinational step of one Freeman code.
//   code         : Freeman code 0..7
//   cur_x, cur_y : current pixel
//   nxt_x, nxt_y : pixel after the step (meaningless when oob)
//   oob          : step leaves 0..IMG_DIM-1 on either axis (no wrap)
module chain_step #(
  parameter int IMG_DIM = chain_pkg::CC_IMG_DIM,
  parameter int ADDR_W  = chain_pkg::CC_ADDR_W
) (
  input  logic [2:0]        code,
  input  logic [ADDR_W-1:0] cur_x,
  input  logic [ADDR_W-1:0] cur_y,
  output logic [ADDR_W-1:0] nxt_x,
  output logic [ADDR_W-1:0] nxt_y,
  output logic              oob
);
  import chain_pkg::*;

  // Two guard bits: one for the carry past IMG_DIM-1, one for sign below 0.
  localparam logic signed [ADDR_W+1:0] C_MAX = (ADDR_W+2)'(IMG_DIM-1);

  step_t                    st;
  logic signed [ADDR_W+1:0] sx, sy;

  always_comb begin
    st    = code_step(code);
    sx    = $signed({2'b00, cur_x}) + $signed({{ADDR_W{st.dx[1]}}, st.dx});
    sy    = $signed({2'b00, cur_y}) + $signed({{ADDR_W{st.dy[1]}}, st.dy});
    oob   = sx[ADDR_W+1] | sy[ADDR_W+1] | (sx > C_MAX) | (sy > C_MAX);
    nxt_x = sx[ADDR_W-1:0];
    nxt_y = sy[ADDR_W-1:0];
  end
endmodule

// File: rtl/chain_code_plotter.sv
// Redraws a Freeman-chain-coded contour into a row-per-word bit-plane RAM.
//   Clk, reset        : clock, async active-low reset
//   start, start_x/y  : begin a contour at the given start pixel (IDLE/DONE only)
//   code_valid/code/code_last/code_ready : code stream, transfer = valid & ready
//   mem_addr/we/wdata/rdata : row RAM, 1-cycle read latency; pixel x at bit IMG_DIM-1-x
//   busy, done, error, closed, perimeter : status
module chain_code_plotter #(
  parameter int IMG_DIM  = chain_pkg::CC_IMG_DIM,
  parameter int ADDR_W   = chain_pkg::CC_ADDR_W,
  parameter int PERIM_W  = chain_pkg::CC_PERIM_W,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_x,
  input  logic [ADDR_W-1:0]  start_y,
  input  logic               code_valid,
  input  logic [2:0]         code,
  input  logic               code_last,
  output logic               code_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [IMG_DIM-1:0] mem_wdata,
  input  logic [IMG_DIM-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               closed,
  output logic [PERIM_W-1:0] perimeter
);
  import chain_pkg::*;

  localparam logic [ADDR_W-1:0]  C_LAST_IDX = ADDR_W'(IMG_DIM-1);
  localparam logic [IMG_DIM-1:0] C_PIX_ONE  = IMG_DIM'(1);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    cur_x, cur_y, org_x, org_y, clr_cnt;
  logic [ADDR_W-1:0]    nxt_x, nxt_y;
  logic                 oob, last_seen, err_q, perim_full;
  logic [IMG_DIM-1:0]   rd_buf;
  logic [PERIM_W-1:0]   perim_q;

  chain_step #(.IMG_DIM(IMG_DIM), .ADDR_W(ADDR_W)) u_step (
    .code (code), .cur_x(cur_x), .cur_y(cur_y),
    .nxt_x(nxt_x), .nxt_y(nxt_y), .oob(oob)
  );

  assign perim_full = &perim_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Outputs are decoded from state so reset drops mem_we the same instant.
  always_comb begin
    state_nxt  = state;
    code_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = CLEAR_EN ? S_CLEAR : S_PLOT_RD;
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
        if (clr_cnt == C_LAST_IDX) state_nxt = S_PLOT_RD;
      end
      S_PLOT_RD: begin
        mem_addr  = cur_y;
        state_nxt = S_PLOT_WAIT;
      end
      S_PLOT_WAIT: begin
        mem_addr  = cur_y;
        state_nxt = S_PLOT_WR;
      end
      S_PLOT_WR: begin
        mem_we    = 1'b1;
        mem_addr  = cur_y;
        mem_wdata = rd_buf | (C_PIX_ONE << (C_LAST_IDX - cur_x));
        state_nxt = last_seen ? S_DONE : S_WAIT_CODE;
      end
      S_WAIT_CODE: begin
        code_ready = 1'b1;
        if (code_valid) state_nxt = (oob || perim_full) ? S_DONE : S_PLOT_RD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cur_x     <= '0;
      cur_y     <= '0;
      org_x     <= '0;
      org_y     <= '0;
      clr_cnt   <= '0;
      rd_buf    <= '0;
      last_seen <= 1'b0;
      err_q     <= 1'b0;
      perim_q   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          cur_x     <= start_x;
          cur_y     <= start_y;
          org_x     <= start_x;
          org_y     <= start_y;
          clr_cnt   <= '0;
          last_seen <= 1'b0;
          err_q     <= 1'b0;
          perim_q   <= '0;
        end
        S_CLEAR:     clr_cnt <= clr_cnt + 1'b1;
        S_PLOT_WAIT: rd_buf  <= mem_rdata;
        S_WAIT_CODE: if (code_valid) begin
          // Rejected steps leave position and count untouched.
          if (oob || perim_full) err_q <= 1'b1;
          else begin
            cur_x     <= nxt_x;
            cur_y     <= nxt_y;
            perim_q   <= perim_q + 1'b1;
            last_seen <= code_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign error     = err_q;
  assign closed    = done && !err_q && (cur_x == org_x) && (cur_y == org_y);
  assign perimeter = perim_q;
endmodule

// File: tb/tb_chain_code_plotter.sv
module tb_chain_code_plotter;
  localparam int DIM = 64;

  logic        Clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [5:0]  start_x = '0, start_y = '0;
  logic        code_valid = 1'b0, code_last = 1'b0;
  logic [2:0]  code = '0;
  logic        code_ready, mem_we, busy, done, error, closed;
  logic [5:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  perimeter;

  always #5 Clk = ~Clk;

  chain_code_plotter dut (
    .Clk(Clk), .reset(reset), .start(start), .start_x(start_x), .start_y(start_y),
    .code_valid(code_valid), .code(code), .code_last(code_last), .code_ready(code_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error), .closed(closed), .perimeter(perimeter)
  );

  // Row RAM with 1-cycle read latency; scr_req fills it with garbage.
  logic [63:0] ram [DIM];
  logic        scr_req = 1'b0;
  always @(posedge Clk) begin
    if (scr_req) for (int r = 0; r < DIM; r++) ram[r] <= {$urandom, $urandom};
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int vectors = 0, miscompares = 0;
  int sent, tmo, lat_err;
  logic [2:0]  cq [$];
  logic [63:0] exp_img [DIM];
  int exp_perim, exp_sent;
  bit exp_err, exp_closed;
  int DX [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int DY [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

  // Reference: walk the code list on integer coordinates.
  task automatic model(input int sx, input int sy);
    int x, y, nx, ny;
    x = sx; y = sy;
    for (int r = 0; r < DIM; r++) exp_img[r] = '0;
    exp_img[y][63-x] = 1'b1;
    exp_perim = 0; exp_err = 0; exp_sent = 0;
    foreach (cq[i]) begin
      nx = x + DX[cq[i]];
      ny = y + DY[cq[i]];
      exp_sent++;
      if (nx < 0 || nx > 63 || ny < 0 || ny > 63 || exp_perim == 255) begin
        exp_err = 1; break;
      end
      x = nx; y = ny; exp_perim++;
      exp_img[y][63-x] = 1'b1;
    end
    exp_closed = !exp_err && x == sx && y == sy;
  endtask

  task automatic scramble();
    @(negedge Clk); scr_req = 1'b1;
    @(negedge Clk); scr_req = 1'b0;
  endtask

  function automatic int bad_rows();
    int b = 0;
    for (int r = 0; r < DIM; r++) if (ram[r] !== exp_img[r]) b++;
    return b;
  endfunction

  // Drives start + cq; records transfers, timeouts and latency violations.
  task automatic drive(input int sx, input int sy, input int gap_max);
    int w;
    @(negedge Clk);
    start_x = 6'(sx); start_y = 6'(sy); start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    sent = 0; tmo = 0; lat_err = 0;
    for (int i = 0; i < cq.size(); i++) begin
      if (done) break;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge Clk);
      code_valid = 1'b1; code = cq[i]; code_last = (i == cq.size() - 1);
      w = 0;
      while (!code_ready && !done && w < 300) begin @(negedge Clk); w++; end
      if (!code_ready) begin
        if (!done) tmo++;
        code_valid = 1'b0; code_last = 1'b0;
        break;
      end
      @(negedge Clk);
      code_valid = 1'b0; code_last = 1'b0; sent++;
      if (!done && i != cq.size() - 1) begin
        for (int k = 1; k <= 4; k++) begin
          if (code_ready !== (k == 4) || mem_we !== (k == 3)) lat_err++;
          if (k < 4) @(negedge Clk);
        end
      end
    end
    w = 0;
    while (!done && w < 300) begin @(negedge Clk); w++; end
    if (!done) tmo++;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({code_ready, mem_we, busy, done, error, closed, perimeter, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b err=%b perim=%0d addr=%0d wdata=%h, want all 0",
               mem_we, busy, done, error, perimeter, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge Clk);
    reset = 1'b1;
  endtask

  task automatic test_square();
    int b;
    cq = '{3'd0, 3'd0, 3'd6, 3'd6, 3'd4, 3'd4, 3'd2, 3'd2};
    scramble(); model(10, 10); drive(10, 10, 0);
    b = bad_rows();
    vectors++; if (perimeter !== 8'd8) begin miscompares++; $display("FAIL square_perim: got %0d want 8", perimeter); end
    vectors++; if ({done, error, closed} !== 3'b101) begin miscompares++; $display("FAIL square_flags: got d/e/c=%b want 101", {done, error, closed}); end
    vectors++; if (b != 0) begin miscompares++; $display("FAIL square_image: %0d bad rows, want 0", b); end
    vectors++; if (sent != 8 || tmo != 0 || lat_err != 0) begin miscompares++; $display("FAIL square_xfer: sent=%0d tmo=%0d lat_err=%0d want 8/0/0", sent, tmo, lat_err); end
  endtask

  task automatic test_edge();
    int b;
    cq = '{3'd0};
    scramble(); model(63, 5); drive(63, 5, 0);
    b = bad_rows();
    vectors++; if (perimeter !== 8'd0) begin miscompares++; $display("FAIL edge_perim: got %0d want 0", perimeter); end
    vectors++; if ({done, error, closed} !== 3'b110) begin miscompares++; $display("FAIL edge_flags: got d/e/c=%b want 110", {done, error, closed}); end
    vectors++; if (b != 0 || ram[5] !== 64'h1) begin miscompares++; $display("FAIL edge_image: %0d bad rows, row5=%h want 1", b, ram[5]); end
  endtask

  task automatic test_diagonal();
    int b;
    cq.delete();
    repeat (63) cq.push_back(3'd7);
    scramble(); model(0, 0); drive(0, 0, 0);
    b = bad_rows();
    vectors++; if (perimeter !== 8'd63) begin miscompares++; $display("FAIL diag_perim: got %0d want 63", perimeter); end
    vectors++; if ({done, error, closed} !== 3'b100) begin miscompares++; $display("FAIL diag_flags: got d/e/c=%b want 100", {done, error, closed}); end
    vectors++; if (b != 0) begin miscompares++; $display("FAIL diag_image: %0d bad rows, want 0", b); end
  endtask

  task automatic test_overflow();
    int b;
    cq.delete();
    for (int i = 0; i < 256; i++) cq.push_back(i[0] ? 3'd4 : 3'd0);
    scramble(); model(30, 30); drive(30, 30, 0);
    b = bad_rows();
    vectors++; if (perimeter !== 8'd255) begin miscompares++; $display("FAIL ovf_perim: got %0d want 255", perimeter); end
    vectors++; if ({done, error, closed} !== 3'b110) begin miscompares++; $display("FAIL ovf_flags: got d/e/c=%b want 110", {done, error, closed}); end
    vectors++; if (sent != 256 || tmo != 0 || lat_err != 0 || b != 0) begin miscompares++; $display("FAIL ovf_xfer: sent=%0d tmo=%0d lat_err=%0d badrows=%0d want 256/0/0/0", sent, tmo, lat_err, b); end
  endtask

  task automatic test_backpressure();
    int b, sx, sy, n;
    for (int t = 0; t < 4; t++) begin
      cq.delete();
      sx = $urandom_range(16, 47); sy = $urandom_range(16, 47); n = $urandom_range(4, 20);
      repeat (n) cq.push_back(3'($urandom_range(0, 7)));
      // Odd trials retrace the walk backwards, giving a closed contour.
      if (t[0]) for (int i = n - 1; i >= 0; i--) cq.push_back(3'(cq[i] + 3'd4));
      scramble(); model(sx, sy); drive(sx, sy, 3);
      b = bad_rows();
      vectors++; if (perimeter !== 8'(exp_perim)) begin miscompares++; $display("FAIL bp%0d_perim: got %0d want %0d", t, perimeter, exp_perim); end
      vectors++; if ({done, error, closed} !== {1'b1, exp_err, exp_closed}) begin miscompares++; $display("FAIL bp%0d_flags: got d/e/c=%b want 1%b%b", t, {done, error, closed}, exp_err, exp_closed); end
      vectors++; if (b != 0) begin miscompares++; $display("FAIL bp%0d_image: %0d bad rows, want 0", t, b); end
      vectors++; if (sent != exp_sent || tmo != 0 || lat_err != 0) begin miscompares++; $display("FAIL bp%0d_xfer: sent=%0d tmo=%0d lat_err=%0d want %0d/0/0", t, sent, tmo, lat_err, exp_sent); end
    end
  endtask

  task automatic test_reset_mid();
    int w, b;
    // Reset while clearing row 20.
    scramble();
    @(negedge Clk); start_x = 6'd20; start_y = 6'd20; start = 1'b1;
    @(negedge Clk); start = 1'b0;
    w = 0;
    while (!(mem_we && mem_addr == 6'd20) && w < 200) begin @(negedge Clk); w++; end
    vectors++; if (!(mem_we && mem_addr == 6'd20)) begin miscompares++; $display("FAIL rst_clear_reach: we=%b addr=%0d want 1/20", mem_we, mem_addr); end
    reset = 1'b0; #1;
    vectors++; if ({code_ready, mem_we, busy, done, error, closed, perimeter, mem_addr, mem_wdata} !== '0) begin miscompares++; $display("FAIL rst_clear_outputs: we=%b busy=%b addr=%0d perim=%0d want all 0", mem_we, busy, mem_addr, perimeter); end
    @(negedge Clk); reset = 1'b1;
    // Reset during the first read-modify-write (start pixel plot).
    @(negedge Clk); start_x = 6'd7; start_y = 6'd9; start = 1'b1;
    @(negedge Clk); start = 1'b0;
    w = 0;
    while (!(mem_we && mem_wdata !== '0) && w < 200) begin @(negedge Clk); w++; end
    vectors++; if (!(mem_we && mem_wdata === 64'h1 << 56)) begin miscompares++; $display("FAIL rst_plot_reach: we=%b wdata=%h want 1/%h", mem_we, mem_wdata, 64'h1 << 56); end
    reset = 1'b0; #1;
    vectors++; if ({code_ready, mem_we, busy, done, error, closed, perimeter, mem_addr, mem_wdata} !== '0) begin miscompares++; $display("FAIL rst_plot_outputs: we=%b busy=%b wdata=%h want all 0", mem_we, busy, mem_wdata); end
    @(negedge Clk); reset = 1'b1;
    // Fresh contour after reset.
    cq = '{3'd6, 3'd2};
    scramble(); model(7, 9); drive(7, 9, 0);
    b = bad_rows();
    vectors++; if ({done, error, closed, perimeter} !== {3'b101, 8'd2} || b != 0) begin miscompares++; $display("FAIL rst_fresh: d/e/c=%b perim=%0d badrows=%0d want 101/2/0", {done, error, closed}, perimeter, b); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_edge();
    test_diagonal();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
